// File: rtl/uart_pixel_packer_if.sv
// Byte-in / word-out bus between the UART receiver, the pixel packer and the SDRAM write FIFO.
interface uart_pixel_packer_if;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        wfifo_full;
  logic        wfifo_wr_en;
  logic [15:0] wfifo_wr_data;

  modport master (
    output rx_done, rx_data, wfifo_full,
    input  wfifo_wr_en, wfifo_wr_data
  );

  modport slave (
    input  rx_done, rx_data, wfifo_full,
    output wfifo_wr_en, wfifo_wr_data
  );
endinterface

// File: rtl/uart_pixel_packer.sv
// Packs UART byte pairs into RGB565 words for the SDRAM write FIFO, one frame at a time.
// Define UART_PACK_SYNC_EN to require an 0xAA 0x55 header before every frame.
module uart_pixel_packer #(
  parameter int FRAME_PIXELS = 307200,
  parameter int GAP_TIMEOUT  = 500000
) (
  input  logic                               clk,
  input  logic                               rst,
  uart_pixel_packer_if.slave                 bus,
  input  logic                               err_clr,
  output logic                               frame_active,
  output logic                               frame_done,
  output logic [$clog2(FRAME_PIXELS+1)-1:0]  pix_cnt,
  output logic                               err_overflow,
  output logic                               err_timeout
);
  localparam int CNT_W = $clog2(FRAME_PIXELS+1);
  localparam int GAP_W = $clog2(GAP_TIMEOUT+1);

`ifdef UART_PACK_SYNC_EN
  typedef enum logic [1:0] {SYNC0, SYNC1, PIX_HI, PIX_LO} state_t;
  localparam state_t RESTART = SYNC0;
  localparam bit     SYNC_EN = 1'b1;
`else
  typedef enum logic {PIX_HI, PIX_LO} state_t;
  localparam state_t RESTART = PIX_HI;
  localparam bit     SYNC_EN = 1'b0;
`endif

  state_t           state, nxt;
  logic [7:0]       hi_byte;
  logic [GAP_W-1:0] gap_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             in_frame, latch_hi, do_write, last, timeout, sync_hit;

  assign in_frame = (state == PIX_HI) || (state == PIX_LO);
  assign cnt_inc  = pix_cnt + CNT_W'(1);

  // A received byte always takes priority over the gap timeout in the same cycle.
  always_comb begin
    nxt      = state;
    latch_hi = 1'b0;
    do_write = 1'b0;
    last     = 1'b0;
    timeout  = 1'b0;
    sync_hit = 1'b0;
    if (bus.rx_done) begin
      case (state)
`ifdef UART_PACK_SYNC_EN
        SYNC0: if (bus.rx_data == 8'hAA) nxt = SYNC1;
        SYNC1: begin
          if (bus.rx_data == 8'h55) begin
            nxt      = PIX_HI;
            sync_hit = 1'b1;
          end else if (bus.rx_data != 8'hAA) begin
            nxt = SYNC0;
          end
        end
`endif
        PIX_HI: begin
          latch_hi = 1'b1;
          nxt      = PIX_LO;
        end
        PIX_LO: begin
          do_write = 1'b1;
          if (cnt_inc == CNT_W'(FRAME_PIXELS)) begin
            last = 1'b1;
            nxt  = RESTART;
          end else begin
            nxt = PIX_HI;
          end
        end
        default: nxt = RESTART;
      endcase
    end else if (in_frame && (gap_cnt == GAP_W'(GAP_TIMEOUT))) begin
      timeout = 1'b1;
      nxt     = RESTART;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= RESTART;
      pix_cnt           <= '0;
      gap_cnt           <= '0;
      bus.wfifo_wr_en   <= 1'b0;
      bus.wfifo_wr_data <= 16'h0000;
      frame_active      <= 1'b0;
      frame_done        <= 1'b0;
      err_overflow      <= 1'b0;
      err_timeout       <= 1'b0;
    end else begin
      state           <= nxt;
      frame_active    <= (nxt == PIX_HI) || (nxt == PIX_LO);
      frame_done      <= last;
      bus.wfifo_wr_en <= do_write && !bus.wfifo_full;
      if (do_write && !bus.wfifo_full) bus.wfifo_wr_data <= {hi_byte, bus.rx_data};

      // Dropped writes still count so the frame stays aligned.
      if (sync_hit)
        pix_cnt <= '0;
      else if (do_write)
        pix_cnt <= (last && !SYNC_EN) ? '0 : cnt_inc;
      else if (timeout && !SYNC_EN)
        pix_cnt <= '0;

      if (bus.rx_done || sync_hit || timeout)
        gap_cnt <= '0;
      else if (in_frame && (gap_cnt != GAP_W'(GAP_TIMEOUT)))
        gap_cnt <= gap_cnt + GAP_W'(1);

      if (do_write && bus.wfifo_full) err_overflow <= 1'b1;
      else if (err_clr)               err_overflow <= 1'b0;

      if (timeout)      err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (latch_hi) hi_byte <= bus.rx_data;
  end
endmodule

// File: doc/uart_pixel_packer.md
# uart_pixel_packer

Frame-assembly stage between the UART byte receiver and the SDRAM write FIFO. Consumes one-byte strobes (`rx_done`/`rx_data`), detects a frame sync header, and packs byte pairs into 16-bit RGB565 words. It drives `wfifo_wr_en`/`wfifo_wr_data` with exactly one frame's worth of pixel words. It also flags dropped writes and stalled transfers so the VGA read path is never fed a torn frame silently.

## Interface
Parameters:
- `FRAME_PIXELS`, 307200: pixel words per frame (640x480); counter width `$clog2(FRAME_PIXELS+1)`.
- `GAP_TIMEOUT`, 500000: idle clk cycles allowed between bytes inside a frame (10 ms at 50 MHz).

Ports:
- `clk`  in  1  byte-clock domain, same clock as the UART receiver (50 MHz).
- `rst`  in  1  synchronous, active-high reset.
- `rx_done`  in  1  single-cycle strobe, `rx_data` valid.
- `rx_data`  in  8  received byte.
- `wfifo_full`  in  1  SDRAM write FIFO full.
- `err_clr`  in  1  single-cycle clear of sticky error flags.
- `wfifo_wr_en`  out  1  write strobe to SDRAM write FIFO.
- `wfifo_wr_data`  out  16  packed pixel word, `{hi_byte, lo_byte}`.
- `frame_active`  out  1  high while in `PIX_HI`/`PIX_LO`.
- `frame_done`  out  1  one-cycle pulse on the last pixel write of a frame.
- `pix_cnt`  out  `$clog2(FRAME_PIXELS+1)`  pixels accepted in the current frame.
- `err_overflow`  out  1  sticky: write attempted while `wfifo_full`.
- `err_timeout`  out  1  sticky: inter-byte gap exceeded inside a frame.

## Operation
- FSM states: `SYNC0`, `SYNC1`, `PIX_HI`, `PIX_LO`.
- `SYNC0`: on byte 0xAA go to `SYNC1`; any other byte is ignored.
- `SYNC1`: byte 0x55 goes to `PIX_HI` and clears `pix_cnt`. Byte 0xAA stays in `SYNC1`. Any other byte returns to `SYNC0`.
- `PIX_HI`: on a byte, latch it as `hi_byte` and go to `PIX_LO`.
- `PIX_LO`: on a byte, form `{hi_byte, rx_data}` and issue a write.
  - `pix_cnt` increments on each write.
  - If `pix_cnt` reaches `FRAME_PIXELS`, pulse `frame_done` and go to `SYNC0`. Otherwise go to `PIX_HI`.
- Overflow: if `wfifo_full`=1 in the cycle the write would issue, `wfifo_wr_en` stays 0, the word is dropped, and `err_overflow` is set. `pix_cnt` still advances, so frame alignment is preserved.
- Timeout: `gap_cnt` clears on every `rx_done` and on entry to `PIX_HI` from `SYNC1`. It increments each cycle in `PIX_HI`/`PIX_LO` and saturates.
  - When `gap_cnt` equals `GAP_TIMEOUT`, set `err_timeout`, discard any latched `hi_byte`, and return to `SYNC0`.
  - Words already written stay in the FIFO.
- Sync bytes are never written. Bytes 0xAA and 0x55 inside a frame are ordinary pixel data.
- `err_clr` clears both sticky flags. If a set condition occurs in the same cycle, the set wins.

## Timing
- Reset values:
  - State `SYNC0`.
  - `wfifo_wr_en`=0, `wfifo_wr_data`=16'h0000.
  - `frame_active`=0, `frame_done`=0, `pix_cnt`=0.
  - `err_overflow`=0, `err_timeout`=0, `gap_cnt`=0.
- All outputs are registered.
- Latency: `wfifo_wr_en` and `wfifo_wr_data` assert the cycle after the `rx_done` carrying the low byte. They are high for exactly one cycle. `wfifo_wr_data` holds its value until the next write.
- `frame_done` coincides with the final `wfifo_wr_en` (or the final dropped-write cycle).
- `frame_active` changes the cycle after the state transition that causes it.
- `rx_done` and the timeout threshold in the same cycle: `rx_done` wins; the byte is processed and `gap_cnt` clears.
- Back-to-back `rx_done` on consecutive cycles must be accepted. The throughput requirement is one byte per cycle.
- `rst` mid-frame: return to `SYNC0` next cycle with all counters and flags cleared; no partial word is written.

## Configuration
- `UART_PACK_SYNC_EN` defined:
  - The 0xAA 0x55 header is required before each frame, as in the FSM above.
- `UART_PACK_SYNC_EN` undefined:
  - `SYNC0` and `SYNC1` are removed. Reset state and the post-frame/post-timeout state are `PIX_HI` with `pix_cnt` cleared.
  - Every received byte is pixel data.
  - A timeout still sets `err_timeout`, then re-enters `PIX_HI` with `pix_cnt`=0.

## Test plan
- Sync enabled, `FRAME_PIXELS`=4: send AA 55 12 34 56 78 9A BC DE F0.
  - Required: four writes 0x1234, 0x5678, 0x9ABC, 0xDEF0.
  - `frame_done` with the 4th write; `frame_active` falls; `pix_cnt`=4.
- False sync: send 11 AA AA 55 then 2 pixels.
  - Required: first write is the first pixel pair; no write contains 0x11 or 0xAA header bytes.
- Overflow: hold `wfifo_full`=1 during the 2nd pixel.
  - Required: only 3 writes (1st, 3rd, 4th words); `err_overflow`=1; `frame_done` still pulses.
  - `err_clr` then gives `err_overflow`=0.
- Timeout with `GAP_TIMEOUT`=20: send header plus 3 bytes, then idle 20 cycles.
  - Required: `err_timeout`=1, state `SYNC0`, only 1 write.
  - A new header plus 4 pixels produces 4 clean writes.
- `rst` asserted between hi and lo byte of pixel 2.
  - Required: all outputs at reset values next cycle; no further writes until a new header.
- `UART_PACK_SYNC_EN` undefined: send 8 bytes from reset.
  - Required: 4 writes; bytes 0xAA and 0x55 are packed as data, e.g. 0xAA55.
